gshare_branch_predictor: RTL and testbench
==========================================

// Module: gshare_branch_predictor
// PURPOSE
// - Next-gen fetch-stage predictor: gshare PHT (PC index XOR global history) plus a PC-indexed tagged BTB.
// - Adds a speculative GHR with mispredict repair, parametrised counter width, a post-reset table-init sweep and perf counters.
// - Sits beside the PC mux: predicts in the fetch cycle; the execute stage returns resolve_* and receives mispredict/redirect_pc.
// PARAMETERS
// - PC_WIDTH    32  PC width; PC[1:0] ignored.
// - INDEX_BITS  10  log2 entries of both PHT and BTB (ENTRIES = 2**INDEX_BITS).
// - GHR_BITS     8  global history length; legal range 1..INDEX_BITS.
// - CTR_BITS     2  PHT saturating counter width, >=2.
// - PERF_BITS   32  width of the perf counters.
// PORTS
// - clk                  in   1          single clock, posedge.
// - rst_n                in   1          asynchronous active-low reset.
// - ready                out  1          1 = init sweep done, predictions valid.
// - pred_req             in   1          fetch is consuming a prediction this cycle.
// - pc_fetch             in   PC_WIDTH   fetch PC.
// - predict_taken        out  1          predicted taken.
// - predict_pc           out  PC_WIDTH   next fetch PC.
// - predict_ghr          out  GHR_BITS   GHR used for this prediction; pipe carries it to resolve_ghr.
// - resolve_valid        in   1          a branch resolved this cycle.
// - resolve_pc           in   PC_WIDTH   PC of the resolved branch.
// - resolve_taken        in   1          actual direction.
// - resolve_target       in   PC_WIDTH   actual taken target.
// - resolve_ghr          in   GHR_BITS   predict_ghr captured at prediction time.
// - resolve_pred_taken   in   1          direction that was predicted.
// - resolve_pred_target  in   PC_WIDTH   target that was predicted.
// - mispredict           out  1          flush and redirect, combinational.
// - redirect_pc          out  PC_WIDTH   resolve_taken ? resolve_target : resolve_pc+4.
// - perf_branches        out  PERF_BITS  count of accepted resolves, saturating.
// - perf_mispredicts     out  PERF_BITS  count of mispredicts, saturating.
// BEHAVIOUR
// - Indexing:
//   - idx(pc) = pc[INDEX_BITS+1:2]; tag = pc[PC_WIDTH-1:INDEX_BITS+2].
//   - PHT fetch index = idx(pc_fetch) ^ {0, ghr_spec}; PHT resolve index = idx(resolve_pc) ^ {0, resolve_ghr}.
//   - BTB is indexed by idx() alone.
// - Prediction (0 latency, combinational):
//   - predict_taken = ready && btb_valid && tag match && PHT ctr MSB.
//   - predict_pc = taken ? btb_target : pc_fetch+4 (mod 2**PC_WIDTH).
//   - predict_ghr = ghr_spec.
// - FSM: ST_INIT -> ST_RUN.
//   - rst_n low forces ST_INIT, init_idx=0, ghr_spec=0, perf=0.
//   - ST_INIT: each cycle writes PHT[init_idx] = 2**(CTR_BITS-1)-1 (weak not-taken) and BTB valid[init_idx] = 0; init_idx++.
//   - Leave ST_INIT after the write of ENTRIES-1, i.e. ready rises exactly ENTRIES cycles after rst_n deasserts.
//   - Tables themselves carry no reset (RAM-inferable); only control regs reset.
// - In ST_INIT: ready=0, predict_taken=0, mispredict=0; resolve_valid ignored (no table, GHR or perf update).
// - mispredict = ready && resolve_valid && (resolve_pred_taken != resolve_taken || (resolve_taken && resolve_pred_target != resolve_target)).
// - Resolve update (ST_RUN, resolve_valid):
//   - PHT counter saturates at 0 and 2**CTR_BITS-1.
//   - If taken: BTB target, tag and valid are written.
//   - Not-taken never invalidates a BTB entry.
// - GHR update, priority order:
//   - mispredict: ghr_spec <= {resolve_ghr[GHR_BITS-2:0], resolve_taken}; the same-cycle fetch shift is dropped.
//   - else pred_req && ready: ghr_spec <= {ghr_spec[GHR_BITS-2:0], predict_taken}.
//   - GHR_BITS=1: the shift is just the new bit.
// - Simultaneous fetch read and resolve write to the same entry: fetch sees the pre-update value (read-before-write).
// - Perf counters increment on accepted resolve / mispredict and saturate at all-ones, no wrap.
// - Reset mid-sweep or mid-run: immediate return to ST_INIT; the sweep restarts at index 0.
// - Output reset values: ready=0, predict_taken=0, predict_ghr=0, mispredict=0, perf_*=0; predict_pc=pc_fetch+4.
// STRUCTURE
// - Package bp_pkg holds:
//   - state enum ST_INIT/ST_RUN;
//   - function idx/tag extraction;
//   - the CTR weak-not-taken init constant.
// - Sub-module bp_sat_ctr #(CTR_BITS): combinational next-counter for (ctr, taken).
//   - Reused by later tournament/TAGE predictors.
// - Tables are plain arrays in this module.
// TESTING
// - Reset sweep, INDEX_BITS=4: rst_n released -> ready low for exactly 16 cycles, then high.
//   - During the sweep, a resolve_valid with taken=1 -> no mispredict, no perf change.
// - Warm-up: PC 0x100 resolved taken to 0x200 twice with GHR=0 -> PHT 01->10->11, BTB valid.
//   - Next fetch of 0x100 with ghr_spec=0 -> predict_taken=1, predict_pc=0x200.
// - GHR repair: ghr_spec=0x5A; resolve_ghr=0x12, taken=1 against predicted not-taken -> mispredict=1, redirect_pc=target.
//   - Same-cycle pred_req is overridden: ghr_spec=0x25 next cycle.
// - Saturation, CTR_BITS=3: 10 taken resolves on one entry -> counter 7 and holds.
//   - 1 not-taken -> 6, still predicts taken.
// - Target mismatch: pred_taken=1, pred_target=0x300, actual taken to 0x400 -> mispredict=1, redirect 0x400.
//   - BTB now holds 0x400.
// - Async reset mid-run: rst_n pulsed low between clock edges -> ready=0 and predict_taken=0 immediately.
//   - perf_* = 0; sweep restarts at 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor family.
// Index/tag extraction works on a 64-bit view of the PC so any PC_WIDTH up to 64 can use it.
package bp_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int index_bits);
        return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int index_bits);
        return pc >> (index_bits + 2);
    endfunction

    // Weak not-taken: the value just below the taken threshold (MSB clear, all lower bits set).
    function automatic int ctr_weak_not_taken(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational next-state for an N-bit saturating direction counter.
module bp_sat_ctr #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                taken,
    output logic [CTR_BITS-1:0] ctr_next
);

    // NOTE: assigning a default first means every path drives ctr_next, so no latch is inferred.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != '1) ctr_next = ctr + CTR_BITS'(1);
        end else begin
            if (ctr != '0) ctr_next = ctr - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with a tagged BTB, speculative GHR with mispredict repair,
// a post-reset table-init sweep and saturating perf counters.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 10,
    parameter int GHR_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int PERF_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ready,
    input  logic                 pred_req,
    input  logic [PC_WIDTH-1:0]  pc_fetch,
    output logic                 predict_taken,
    output logic [PC_WIDTH-1:0]  predict_pc,
    output logic [GHR_BITS-1:0]  predict_ghr,
    input  logic                 resolve_valid,
    input  logic [PC_WIDTH-1:0]  resolve_pc,
    input  logic                 resolve_taken,
    input  logic [PC_WIDTH-1:0]  resolve_target,
    input  logic [GHR_BITS-1:0]  resolve_ghr,
    input  logic                 resolve_pred_taken,
    input  logic [PC_WIDTH-1:0]  resolve_pred_target,
    output logic                 mispredict,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [PERF_BITS-1:0] perf_branches,
    output logic [PERF_BITS-1:0] perf_mispredicts
);

    localparam int ENTRIES  = 2 ** INDEX_BITS;
    localparam int TAG_BITS = PC_WIDTH - INDEX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

    bp_state_e             state;
    logic [INDEX_BITS-1:0] init_idx;
    logic [GHR_BITS-1:0]   ghr_spec;

    logic [CTR_BITS-1:0]   pht        [ENTRIES];
    logic                  btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0]   btb_tag    [ENTRIES];
    logic [PC_WIDTH-1:0]   btb_target [ENTRIES];

    logic [63:0] fetch_idx_w, fetch_tag_w, res_idx_w, res_tag_w;
    logic [INDEX_BITS-1:0] fetch_idx, res_idx, pht_fidx, pht_ridx;
    logic [TAG_BITS-1:0]   fetch_tag, res_tag;
    logic [CTR_BITS-1:0]   ctr_next;
    logic                  unused_bits;

    assign fetch_idx_w = pc_index(64'(pc_fetch), INDEX_BITS);
    assign fetch_tag_w = pc_tag(64'(pc_fetch), INDEX_BITS);
    assign res_idx_w   = pc_index(64'(resolve_pc), INDEX_BITS);
    assign res_tag_w   = pc_tag(64'(resolve_pc), INDEX_BITS);

    assign fetch_idx = fetch_idx_w[INDEX_BITS-1:0];
    assign fetch_tag = fetch_tag_w[TAG_BITS-1:0];
    assign res_idx   = res_idx_w[INDEX_BITS-1:0];
    assign res_tag   = res_tag_w[TAG_BITS-1:0];
    assign unused_bits = ^{fetch_idx_w[63:INDEX_BITS], fetch_tag_w[63:TAG_BITS],
                           res_idx_w[63:INDEX_BITS], res_tag_w[63:TAG_BITS]};

    assign pht_fidx = fetch_idx ^ INDEX_BITS'(ghr_spec);
    assign pht_ridx = res_idx ^ INDEX_BITS'(resolve_ghr);

    assign ready         = (state == ST_RUN);
    assign predict_taken = ready && btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag)
                           && pht[pht_fidx][CTR_BITS-1];
    assign predict_pc    = predict_taken ? btb_target[fetch_idx] : pc_fetch + PC_WIDTH'(4);
    assign predict_ghr   = ghr_spec;

    assign mispredict  = ready && resolve_valid &&
                         ((resolve_pred_taken != resolve_taken) ||
                          (resolve_taken && (resolve_pred_target != resolve_target)));
    assign redirect_pc = resolve_taken ? resolve_target : resolve_pc + PC_WIDTH'(4);

    bp_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
        .ctr      (pht[pht_ridx]),
        .taken    (resolve_taken),
        .ctr_next (ctr_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_INIT;
            init_idx         <= '0;
            ghr_spec         <= '0;
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + INDEX_BITS'(1);
                    if (init_idx == '1) state <= ST_RUN;
                end
                ST_RUN: begin
                    // Repair from the resolving branch's history wins over the fetch shift.
                    if (mispredict)
                        ghr_spec <= GHR_BITS'({resolve_ghr, resolve_taken});
                    else if (pred_req)
                        ghr_spec <= GHR_BITS'({ghr_spec, predict_taken});
                    if (resolve_valid && (perf_branches != '1))
                        perf_branches <= perf_branches + PERF_BITS'(1);
                    if (mispredict && (perf_mispredicts != '1))
                        perf_mispredicts <= perf_mispredicts + PERF_BITS'(1);
                end
            endcase
        end
    end

    // NOTE: the tables have no reset so they map onto RAM; the init sweep gives them known contents.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            pht[init_idx]       <= CTR_WNT;
            btb_valid[init_idx] <= 1'b0;
        end else if (resolve_valid) begin
            pht[pht_ridx] <= ctr_next;
            if (resolve_taken) begin
                btb_valid[res_idx]  <= 1'b1;
                btb_tag[res_idx]    <= res_tag;
                btb_target[res_idx] <= resolve_target;
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor (INDEX_BITS=8, GHR_BITS=8, CTR_BITS=3).
module tb_gshare_branch_predictor;

    localparam int PC_WIDTH   = 32;
    localparam int INDEX_BITS = 8;
    localparam int GHR_BITS   = 8;
    localparam int CTR_BITS   = 3;
    localparam int PERF_BITS  = 32;
    localparam int ENTRIES    = 2 ** INDEX_BITS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 ready;
    logic                 pred_req = 1'b0;
    logic [PC_WIDTH-1:0]  pc_fetch = '0;
    logic                 predict_taken;
    logic [PC_WIDTH-1:0]  predict_pc;
    logic [GHR_BITS-1:0]  predict_ghr;
    logic                 resolve_valid = 1'b0;
    logic [PC_WIDTH-1:0]  resolve_pc = '0;
    logic                 resolve_taken = 1'b0;
    logic [PC_WIDTH-1:0]  resolve_target = '0;
    logic [GHR_BITS-1:0]  resolve_ghr = '0;
    logic                 resolve_pred_taken = 1'b0;
    logic [PC_WIDTH-1:0]  resolve_pred_target = '0;
    logic                 mispredict;
    logic [PC_WIDTH-1:0]  redirect_pc;
    logic [PERF_BITS-1:0] perf_branches;
    logic [PERF_BITS-1:0] perf_mispredicts;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gshare_branch_predictor #(
        .PC_WIDTH(PC_WIDTH), .INDEX_BITS(INDEX_BITS), .GHR_BITS(GHR_BITS),
        .CTR_BITS(CTR_BITS), .PERF_BITS(PERF_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready), .pred_req(pred_req), .pc_fetch(pc_fetch),
        .predict_taken(predict_taken), .predict_pc(predict_pc), .predict_ghr(predict_ghr),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_ghr(resolve_ghr),
        .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_req = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        resolve_pred_taken = 1'b0;
    endtask

    task automatic set_resolve(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                               input logic [7:0] ghr, input logic ptaken, input logic [31:0] ptarget);
        resolve_valid = 1'b1;
        resolve_pc = pc;
        resolve_taken = taken;
        resolve_target = target;
        resolve_ghr = ghr;
        resolve_pred_taken = ptaken;
        resolve_pred_target = ptarget;
    endtask

    // Counts edges from reset release until ready; optionally pokes a resolve mid-sweep.
    task automatic wait_sweep(input logic probe);
        int cnt = 0;
        while (ready !== 1'b1 && cnt < 1000) begin
            if (probe && cnt == 5) begin
                set_resolve(32'h100, 1'b1, 32'h200, 8'h00, 1'b0, 32'h0);
                #1;
                total_cnt++; if (mispredict !== 1'b0) $display("FAIL sweep_mispredict: got %b want 0", mispredict); else pass_cnt++;
            end
            step();
            if (probe && cnt == 5) idle();
            cnt++;
        end
        total_cnt++; if (cnt != ENTRIES) $display("FAIL sweep_length: got %0d cycles want %0d", cnt, ENTRIES); else pass_cnt++;
        if (probe) begin
            total_cnt++; if (perf_branches !== 32'd0) $display("FAIL sweep_perf_br: got %0d want 0", perf_branches); else pass_cnt++;
            total_cnt++; if (predict_ghr !== 8'h00) $display("FAIL sweep_ghr: got %h want 00", predict_ghr); else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        pc_fetch = 32'h1000;
        step();
        step();
        total_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else pass_cnt++;
        total_cnt++; if (predict_taken !== 1'b0) $display("FAIL rst_taken: got %b want 0", predict_taken); else pass_cnt++;
        total_cnt++; if (predict_pc !== 32'h1004) $display("FAIL rst_pc: got %h want 00001004", predict_pc); else pass_cnt++;
        total_cnt++; if (predict_ghr !== 8'h00) $display("FAIL rst_ghr: got %h want 00", predict_ghr); else pass_cnt++;
        total_cnt++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0)
            $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_branches, perf_mispredicts); else pass_cnt++;
        rst_n = 1'b1;
        wait_sweep(1'b1);
    endtask

    task automatic test_warmup();
        pc_fetch = 32'h100;
        #1;
        total_cnt++; if (predict_taken !== 1'b0 || predict_pc !== 32'h104)
            $display("FAIL warm_cold: got taken=%b pc=%h want 0/00000104", predict_taken, predict_pc); else pass_cnt++;
        set_resolve(32'h100, 1'b1, 32'h200, 8'h00, 1'b1, 32'h200);
        #1;
        total_cnt++; if (mispredict !== 1'b0) $display("FAIL warm_mispredict: got %b want 0", mispredict); else pass_cnt++;
        total_cnt++; if (predict_taken !== 1'b0) $display("FAIL warm_read_before_write: got %b want 0", predict_taken); else pass_cnt++;
        step();
        total_cnt++; if (predict_taken !== 1'b1) $display("FAIL warm_first_update: got %b want 1", predict_taken); else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++; if (predict_taken !== 1'b1 || predict_pc !== 32'h200)
            $display("FAIL warm_predict: got taken=%b pc=%h want 1/00000200", predict_taken, predict_pc); else pass_cnt++;
        total_cnt++; if (perf_branches !== 32'd2 || perf_mispredicts !== 32'd0)
            $display("FAIL warm_perf: got %0d/%0d want 2/0", perf_branches, perf_mispredicts); else pass_cnt++;
    endtask

    task automatic test_ghr_repair();
        set_resolve(32'h800, 1'b0, 32'h0, 8'h2D, 1'b1, 32'h0);
        #1;
        total_cnt++; if (mispredict !== 1'b1 || redirect_pc !== 32'h804)
            $display("FAIL repair_nt: got mp=%b redirect=%h want 1/00000804", mispredict, redirect_pc); else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++; if (predict_ghr !== 8'h5A) $display("FAIL repair_ghr_5a: got %h want 5a", predict_ghr); else pass_cnt++;
        pred_req = 1'b1;
        pc_fetch = 32'h100;
        set_resolve(32'hA00, 1'b1, 32'hA40, 8'h12, 1'b0, 32'h0);
        #1;
        total_cnt++; if (mispredict !== 1'b1 || redirect_pc !== 32'hA40)
            $display("FAIL repair_taken: got mp=%b redirect=%h want 1/00000a40", mispredict, redirect_pc); else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++; if (predict_ghr !== 8'h25) $display("FAIL repair_ghr_25: got %h want 25", predict_ghr); else pass_cnt++;
        total_cnt++; if (perf_branches !== 32'd4 || perf_mispredicts !== 32'd2)
            $display("FAIL repair_perf: got %0d/%0d want 4/2", perf_branches, perf_mispredicts); else pass_cnt++;
    endtask

    task automatic test_saturation();
        pc_fetch = 32'hC00;
        for (int i = 0; i < 10; i++) begin
            set_resolve(32'hC00, 1'b1, 32'hD00, 8'h25, 1'b1, 32'hD00);
            step();
        end
        idle();
        #1;
        total_cnt++; if (predict_taken !== 1'b1 || predict_pc !== 32'hD00)
            $display("FAIL sat_taken: got taken=%b pc=%h want 1/00000d00", predict_taken, predict_pc); else pass_cnt++;
        // Counter at 7 needs four not-taken resolves to drop below the taken threshold.
        for (int i = 0; i < 4; i++) begin
            set_resolve(32'hC00, 1'b0, 32'h0, 8'h25, 1'b0, 32'h0);
            step();
            idle();
            #1;
            total_cnt++; if (predict_taken !== (i < 3))
                $display("FAIL sat_nt_%0d: got %b want %b", i, predict_taken, (i < 3)); else pass_cnt++;
        end
        total_cnt++; if (perf_branches !== 32'd18 || perf_mispredicts !== 32'd2)
            $display("FAIL sat_perf: got %0d/%0d want 18/2", perf_branches, perf_mispredicts); else pass_cnt++;
    endtask

    task automatic test_ghr_shift();
        pc_fetch = 32'h104;
        pred_req = 1'b1;
        #1;
        total_cnt++; if (predict_taken !== 1'b0) $display("FAIL shift_taken: got %b want 0", predict_taken); else pass_cnt++;
        step();
        pred_req = 1'b0;
        #1;
        total_cnt++; if (predict_ghr !== 8'h4A) $display("FAIL shift_ghr: got %h want 4a", predict_ghr); else pass_cnt++;
        pc_fetch = 32'hFFFF_FFFC;
        #1;
        total_cnt++; if (predict_taken !== 1'b0 || predict_pc !== 32'h0)
            $display("FAIL shift_wrap: got taken=%b pc=%h want 0/00000000", predict_taken, predict_pc); else pass_cnt++;
    endtask

    task automatic test_target_mismatch();
        pc_fetch = 32'hC00;
        set_resolve(32'hC00, 1'b1, 32'h400, 8'hFF, 1'b1, 32'h300);
        #1;
        total_cnt++; if (mispredict !== 1'b1 || redirect_pc !== 32'h400)
            $display("FAIL tgt_mispredict: got mp=%b redirect=%h want 1/00000400", mispredict, redirect_pc); else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++; if (predict_ghr !== 8'hFF) $display("FAIL tgt_ghr: got %h want ff", predict_ghr); else pass_cnt++;
        total_cnt++; if (predict_taken !== 1'b1 || predict_pc !== 32'h400)
            $display("FAIL tgt_btb: got taken=%b pc=%h want 1/00000400", predict_taken, predict_pc); else pass_cnt++;
        total_cnt++; if (perf_branches !== 32'd19 || perf_mispredicts !== 32'd3)
            $display("FAIL tgt_perf: got %0d/%0d want 19/3", perf_branches, perf_mispredicts); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (ready !== 1'b0 || predict_taken !== 1'b0)
            $display("FAIL arst_ready_taken: got %b/%b want 0/0", ready, predict_taken); else pass_cnt++;
        total_cnt++; if (predict_pc !== 32'hC04 || predict_ghr !== 8'h00)
            $display("FAIL arst_pc_ghr: got %h/%h want 00000c04/00", predict_pc, predict_ghr); else pass_cnt++;
        total_cnt++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0)
            $display("FAIL arst_perf: got %0d/%0d want 0/0", perf_branches, perf_mispredicts); else pass_cnt++;
        rst_n = 1'b1;
        // Interrupt the sweep part-way; the restarted sweep must again take the full length.
        repeat (100) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        wait_sweep(1'b0);
        #1;
        total_cnt++; if (predict_taken !== 1'b0 || predict_pc !== 32'hC04)
            $display("FAIL arst_btb_cleared: got taken=%b pc=%h want 0/00000c04", predict_taken, predict_pc); else pass_cnt++;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_warmup();
        test_ghr_repair();
        test_saturation();
        test_ghr_shift();
        test_target_mismatch();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
